// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: serial coefficient loader with shadow/active banks and a stalling sample sequencer for fir_filter.
// Define FIR_CTRL_FLUSH_EN to flush the filter delay line with zeros after every bank swap.
module fir_coef_ctrl #(
  parameter int NB    = 11,
  parameter int NTAPS = 11
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [NB-1:0]       CFG_DATA,
  input  logic                CFG_LAST,
  input  logic                COMMIT,
  output logic                ERR,
  input  logic [NB-1:0]       DIN_S,
  input  logic                VIN_S,
  output logic                READY_S,
  output logic [NB-1:0]       DOUT_F,
  output logic                VOUT_F,
  output logic [NTAPS*NB-1:0] B_FLAT,
  output logic                BUSY,
  output logic                MASK_O
);
  localparam int IW = $clog2(NTAPS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, ARMED, DRAIN, SWAP, FLUSH} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic err_d, beat, accept;
  logic [NB-1:0] shadow_q [NTAPS];
  logic [NB-1:0] active_q [NTAPS];
  assign beat   = CFG_VALID & CFG_READY;
  assign accept = VIN_S & READY_S;
`ifdef FIR_CTRL_FLUSH_EN
  localparam logic [IW-1:0] FLUSH_LAST = IW'(NTAPS - 2);
  logic [IW-1:0] fcnt_q;
  logic [1:0] tail_q, tail_d;
  logic mask_q;
  // mask stays up two extra cycles to cover fir_filter output latency
  assign tail_d = (state_q == FLUSH && fcnt_q == FLUSH_LAST) ? 2'd2 : (tail_q != 2'd0 ? tail_q - 2'd1 : 2'd0);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      fcnt_q <= '0;
      tail_q <= '0;
      mask_q <= 1'b0;
    end else begin
      fcnt_q <= state_q == FLUSH ? fcnt_q + 1'b1 : '0;
      tail_q <= tail_d;
      mask_q <= state_d == FLUSH || tail_d != 2'd0;
    end
  assign MASK_O = mask_q;
`else
  assign MASK_O = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = ERR;
    case (state_q)
      IDLE, LOAD: if (beat) begin
        state_d = idx_q == LAST_IDX ? ARMED : (CFG_LAST ? IDLE : LOAD);
        idx_d   = (idx_q == LAST_IDX || CFG_LAST) ? '0 : idx_q + 1'b1;
        err_d   = ERR | (idx_q == LAST_IDX ? ~CFG_LAST : CFG_LAST);
      end
      ARMED: if (COMMIT) state_d = DRAIN;
      DRAIN: state_d = SWAP;
`ifdef FIR_CTRL_FLUSH_EN
      SWAP:  state_d = FLUSH;
      FLUSH: if (fcnt_q == FLUSH_LAST) state_d = IDLE;
`else
      SWAP:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ERR       <= 1'b0;
      CFG_READY <= 1'b0;
      READY_S   <= 1'b0;
      BUSY      <= 1'b0;
      DOUT_F    <= '0;
      VOUT_F    <= 1'b0;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ERR       <= err_d;
      CFG_READY <= state_d == IDLE || state_d == LOAD;
      READY_S   <= state_d == IDLE || state_d == LOAD || state_d == ARMED;
      BUSY      <= state_d == DRAIN || state_d == SWAP || state_d == FLUSH;
      VOUT_F    <= accept | (state_d == FLUSH);
      if (state_d == FLUSH) DOUT_F <= '0;
      else if (accept) DOUT_F <= DIN_S;
      if (beat) shadow_q[idx_q] <= CFG_DATA;
      if (state_q == SWAP) active_q <= shadow_q;
    end
  genvar i;
  for (i = 0; i < NTAPS; i++) begin : g_bank
    assign B_FLAT[i*NB +: NB] = active_q[i];
  end
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb_fir_coef_ctrl: directed and randomized checks of fir_coef_ctrl against a transaction-level model.
module tb_fir_coef_ctrl;
  localparam int NB = 11;
  localparam int NTAPS = 11;
`ifdef FIR_CTRL_FLUSH_EN
  localparam int FL = NTAPS - 1;
`else
  localparam int FL = 0;
`endif
  localparam int MASKN = FL > 0 ? FL + 2 : 0;
  localparam int W = NTAPS * NB;

  logic CLK = 0, RST = 1, CFG_VALID = 0, CFG_LAST = 0, COMMIT = 0, VIN_S = 0;
  logic [NB-1:0] CFG_DATA = '0, DIN_S = '0;
  logic CFG_READY, ERR, READY_S, VOUT_F, BUSY, MASK_O;
  logic [NB-1:0] DOUT_F;
  logic [W-1:0] B_FLAT;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  logic [NB-1:0] m_shadow [NTAPS];
  logic [W-1:0] e_bflat;
  logic [NB-1:0] e_dout;
  logic e_vout, e_cfg_ready, e_ready_s, e_err, e_busy, e_mask;
  int m_cnt, m_k, m_mask_left;
  bit m_armed;

  always #5 CLK = ~CLK;

  fir_coef_ctrl #(.NB(NB), .NTAPS(NTAPS)) dut (
    .CLK(CLK), .RST(RST), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_DATA(CFG_DATA),
    .CFG_LAST(CFG_LAST), .COMMIT(COMMIT), .ERR(ERR), .DIN_S(DIN_S), .VIN_S(VIN_S),
    .READY_S(READY_S), .DOUT_F(DOUT_F), .VOUT_F(VOUT_F), .B_FLAT(B_FLAT), .BUSY(BUSY), .MASK_O(MASK_O)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_shadow[i]) m_shadow[i] = '0;
    e_bflat = '0; e_dout = '0; e_vout = 0; e_cfg_ready = 0; e_ready_s = 0;
    e_err = 0; e_busy = 0; e_mask = 0;
    m_cnt = 0; m_k = -1; m_mask_left = 0; m_armed = 0;
  endtask

  // m_k counts cycles since an accepted commit: 0 drain, 1 swap, 2.. flush samples
  task automatic model_step();
    bit acc, bt, go;
    if (RST) begin
      model_reset();
      return;
    end
    acc = VIN_S && e_ready_s;
    bt  = CFG_VALID && e_cfg_ready;
    go  = COMMIT && m_armed;
    e_vout = acc;
    if (acc) e_dout = DIN_S;
    if (m_k >= 0) begin
      if (m_k == 1) for (int i = 0; i < NTAPS; i++) e_bflat[i*NB +: NB] = m_shadow[i];
      m_k++;
      if (m_k >= 2 + FL) m_k = -1;
    end
    if (m_k >= 2) begin
      e_dout = '0;
      e_vout = 1;
    end
    if (m_mask_left > 0) m_mask_left--;
    if (m_k == 2) m_mask_left = FL + 2;
    if (bt) begin
      m_shadow[m_cnt] = CFG_DATA;
      m_cnt++;
      if (m_cnt == NTAPS) begin
        m_armed = 1;
        m_cnt = 0;
        if (!CFG_LAST) e_err = 1;
      end else if (CFG_LAST) begin
        e_err = 1;
        m_cnt = 0;
      end
    end
    if (go) begin
      m_armed = 0;
      m_k = 0;
    end
    e_busy = m_k >= 0;
    e_ready_s = !e_busy;
    e_cfg_ready = !e_busy && !m_armed;
    e_mask = m_mask_left > 0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic load(input int n, input int last_at, input int base);
    for (int k = 0; k < n; k++) begin
      CFG_VALID = 1;
      CFG_DATA = NB'(base + k);
      CFG_LAST = (k == last_at);
      cyc();
    end
    CFG_VALID = 0;
    CFG_LAST = 0;
  endtask

  always @(negedge CLK) if (chk_en) begin
    check("cfg_ready", W'(CFG_READY), W'(e_cfg_ready));
    check("ready_s", W'(READY_S), W'(e_ready_s));
    check("dout_f", W'(DOUT_F), W'(e_dout));
    check("vout_f", W'(VOUT_F), W'(e_vout));
    check("err", W'(ERR), W'(e_err));
    check("busy", W'(BUSY), W'(e_busy));
    check("mask_o", W'(MASK_O), W'(e_mask));
    check("b_flat", B_FLAT, e_bflat);
  end

  initial begin
    int n_lo, n_zero, n_mask;
    model_reset();
    @(negedge CLK);
    chk_en = 1;
    repeat (2) cyc();
    check("rst_ready_s", W'(READY_S), W'(0));
    check("rst_cfg_ready", W'(CFG_READY), W'(0));
    check("rst_bflat", B_FLAT, '0);
    #2 RST = 0;
    cyc();
    check("rel_cfg_ready", W'(CFG_READY), W'(1));
    check("rel_ready_s", W'(READY_S), W'(1));
    VIN_S = 1; DIN_S = 11'd100; cyc();
    check("pt_100", W'({VOUT_F, DOUT_F}), W'({1'b1, 11'd100}));
    DIN_S = 11'h79C; cyc();
    check("pt_m100", W'({VOUT_F, DOUT_F}), W'({1'b1, 11'h79C}));
    DIN_S = 11'd1023; cyc();
    check("pt_1023", W'({VOUT_F, DOUT_F}), W'({1'b1, 11'd1023}));
    VIN_S = 0; DIN_S = 11'd5; cyc();
    check("pt_hold", W'({VOUT_F, DOUT_F}), W'({1'b0, 11'd1023}));
    load(NTAPS, NTAPS - 1, 1);
    check("armed_cfg_ready", W'(CFG_READY), W'(0));
    COMMIT = 1; cyc(); COMMIT = 0;
    check("commit_busy", W'(BUSY), W'(1));
    cyc(); cyc();
    check("bank_b0", W'(B_FLAT[10:0]), W'(11'd1));
    check("bank_b10", W'(B_FLAT[120:110]), W'(11'd11));
    repeat (20) cyc();
    load(5, 4, 50);
    check("early_err", W'(ERR), W'(1));
    check("early_cfg_ready", W'(CFG_READY), W'(1));
    COMMIT = 1; cyc(); COMMIT = 0;
    check("early_commit_busy", W'(BUSY), W'(0));
    check("early_bank_b0", W'(B_FLAT[10:0]), W'(11'd1));
    load(NTAPS, NTAPS - 1, 200);
    VIN_S = 1; DIN_S = 11'd77; COMMIT = 1; cyc();
    COMMIT = 0; DIN_S = 11'd55;
    check("fwd_commit_sample", W'({VOUT_F, DOUT_F}), W'({1'b1, 11'd77}));
    n_lo = 0; n_zero = 0; n_mask = 0;
    for (int i = 0; i < 25; i++) begin
      if (!READY_S) n_lo++;
      if (VOUT_F && DOUT_F == '0) n_zero++;
      if (MASK_O) n_mask++;
      COMMIT = (i == 1);
      cyc();
    end
    COMMIT = 0;
    check("stall_cycles", W'(n_lo), W'(FL + 2));
    check("flush_zeros", W'(n_zero), W'(FL));
    check("mask_cycles", W'(n_mask), W'(MASKN));
    check("post_busy", W'(BUSY), W'(0));
    check("new_bank_b0", W'(B_FLAT[10:0]), W'(11'd200));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 RST = 1;
        model_reset();
        cyc(); cyc();
        #2 RST = 0;
      end
      CFG_VALID = $urandom_range(0, 2) != 0;
      CFG_DATA = NB'($urandom);
      CFG_LAST = (m_cnt == NTAPS - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
      COMMIT = $urandom_range(0, 5) == 0;
      VIN_S = $urandom_range(0, 1) != 0;
      DIN_S = NB'($urandom);
      cyc();
    end
    CFG_VALID = 0; CFG_LAST = 0; COMMIT = 0; VIN_S = 0;
    repeat (20) cyc();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
